// File: rtl/miner_core_pass_ctrl.sv
// Sequencer for a multi-pass hash core. Each pass runs a message-schedule phase,
// a compression phase and a single add cycle. A job then ends with a one-cycle DONE pulse.
module miner_core_pass_ctrl #(
    parameter int NUM_PASSES  = 3,
    parameter int MSA_ROUNDS  = 48,
    parameter int COMP_ROUNDS = 64,
    localparam int CNT_W      = 7,
    localparam int PASS_W     = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              hash_enable,
    input  logic              skip_first,
    input  logic              abort,
    output logic              msa_en,
    output logic              comp_en,
    output logic              add_en,
    output logic [CNT_W-1:0]  round_idx,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              finished
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MSA,
        ST_COMP,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0]  MSA_LAST  = CNT_W'(MSA_ROUNDS - 1);
    localparam logic [CNT_W-1:0]  COMP_LAST = CNT_W'(COMP_ROUNDS - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
    // Midstate reuse only makes sense when there is a later pass to jump to.
    localparam logic              SKIP_OK   = (NUM_PASSES > 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic [PASS_W-1:0]  pass_q,  pass_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        pass_d  = pass_q;
        // Cancelling a job outranks every other transition, including leaving DONE.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            round_d = '0;
            pass_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    round_d = '0;
                    pass_d  = '0;
                    if (hash_enable && !abort) begin
                        state_d = ST_MSA;
                        pass_d  = (skip_first && SKIP_OK) ? PASS_W'(1) : '0;
                    end
                end
                ST_MSA: begin
                    if (round_q == MSA_LAST) begin
                        state_d = ST_COMP;
                        round_d = '0;
                    end else begin
                        round_d = round_q + CNT_W'(1);
                    end
                end
                ST_COMP: begin
                    if (round_q == COMP_LAST) begin
                        state_d = ST_ADD;
                        round_d = '0;
                    end else begin
                        round_d = round_q + CNT_W'(1);
                    end
                end
                ST_ADD: begin
                    round_d = '0;
                    if (pass_q == PASS_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MSA;
                        pass_d  = pass_q + PASS_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    round_d = '0;
                    pass_d  = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    round_d = '0;
                    pass_d  = '0;
                end
            endcase
        end
    end

    assign msa_en    = (state_q == ST_MSA);
    assign comp_en   = (state_q == ST_COMP);
    assign add_en    = (state_q == ST_ADD);
    assign busy      = (state_q != ST_IDLE);
    assign finished  = (state_q == ST_DONE);
    assign round_idx = round_q;
    assign pass_idx  = pass_q;

endmodule

// File: tb/tb_miner_core_pass_ctrl.sv
// Bench for miner_core_pass_ctrl: a default instance and a 1/1/1 instance share the
// stimulus and are checked every cycle against a job-position model, plus directed jobs.
module tb_miner_core_pass_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst       = 1'b0;
    logic hash_enable = 1'b0;
    logic skip_first  = 1'b0;
    logic abort       = 1'b0;

    logic       a_msa, a_comp, a_add, a_busy, a_fin;
    logic [6:0] a_round;
    logic [2:0] a_pass;
    logic       b_msa, b_comp, b_add, b_busy, b_fin;
    logic [6:0] b_round;
    logic [2:0] b_pass;

    miner_core_pass_ctrl u_a (
        .clk(clk), .n_rst(n_rst), .hash_enable(hash_enable), .skip_first(skip_first),
        .abort(abort), .msa_en(a_msa), .comp_en(a_comp), .add_en(a_add),
        .round_idx(a_round), .pass_idx(a_pass), .busy(a_busy), .finished(a_fin)
    );

    miner_core_pass_ctrl #(.NUM_PASSES(1), .MSA_ROUNDS(1), .COMP_ROUNDS(1)) u_b (
        .clk(clk), .n_rst(n_rst), .hash_enable(hash_enable), .skip_first(skip_first),
        .abort(abort), .msa_en(b_msa), .comp_en(b_comp), .add_en(b_add),
        .round_idx(b_round), .pass_idx(b_pass), .busy(b_busy), .finished(b_fin)
    );

    logic [14:0] a_out, b_out;
    assign a_out = {a_msa, a_comp, a_add, a_round, a_pass, a_busy, a_fin};
    assign b_out = {b_msa, b_comp, b_add, b_round, b_pass, b_busy, b_fin};

    // A job is a position k counted from its first MSA cycle; everything else follows.
    typedef struct packed {
        bit active;
        int k;
        int sp;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t s, int np, int m, int c, bit he, bit sf, bit ab);
        mdl_t n = s;
        if (!s.active) begin
            if (he && !ab) begin
                n.active = 1'b1;
                n.k      = 0;
                n.sp     = (sf && np > 1) ? 1 : 0;
            end
        end else if (ab) begin
            n = '0;
        end else if (s.k == (np - s.sp) * (m + c + 1)) begin
            n = '0;
        end else begin
            n.k = s.k + 1;
        end
        return n;
    endfunction

    function automatic logic [14:0] mexp(mdl_t s, int np, int m, int c);
        int L, p, r;
        logic [2:0] pd;
        if (!s.active) return '0;
        L = m + c + 1;
        if (s.k == (np - s.sp) * L) begin
            pd = 3'(np - 1);
            return {3'b000, 7'd0, pd, 2'b11};
        end
        p  = s.sp + s.k / L;
        r  = s.k % L;
        pd = 3'(p);
        if (r < m)          return {3'b100, 7'(r), pd, 2'b10};
        else if (r < m + c) return {3'b010, 7'(r - m), pd, 2'b10};
        else                return {3'b001, 7'd0, pd, 2'b10};
    endfunction

    mdl_t ma = '0;
    mdl_t mb = '0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mstep(ma, 3, 48, 64, hash_enable, skip_first, abort);
            mb <= mstep(mb, 1, 1, 1, hash_enable, skip_first, abort);
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            vectors = vectors + 2;
            if (a_out !== mexp(ma, 3, 48, 64)) begin
                miscompares = miscompares + 1;
                $display("FAIL cycle_a t=%0t dut=%h model=%h", $time, a_out, mexp(ma, 3, 48, 64));
            end
            if (b_out !== mexp(mb, 1, 1, 1)) begin
                miscompares = miscompares + 1;
                $display("FAIL cycle_b t=%0t dut=%h model=%h", $time, b_out, mexp(mb, 1, 1, 1));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    int fin1, fin2, next_msa, busy_cnt, first_comp, last_add, b_fin_cyc, pass1, b_pass1;

    // Launch one job and watch it for len cycles; cycle 1 follows the sampling edge.
    task automatic run_job(input bit sf, input bit hold, input int abort_at,
                           input int rst_at, input int len);
        fin1 = 0; fin2 = 0; next_msa = 0; busy_cnt = 0;
        first_comp = 0; last_add = 0; b_fin_cyc = 0; pass1 = -1; b_pass1 = -1;
        @(posedge clk);
        #1;
        hash_enable = 1'b1;
        skip_first  = sf;
        @(posedge clk);
        #1;
        if (!hold) begin
            hash_enable = 1'b0;
            skip_first  = 1'b0;
        end
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == 1) begin
                pass1   = int'(a_pass);
                b_pass1 = int'(b_pass);
            end
            if (a_busy) busy_cnt++;
            if (a_comp && first_comp == 0) first_comp = c;
            if (a_add) last_add = c;
            if (a_msa && fin1 != 0 && next_msa == 0) next_msa = c;
            if (a_fin) begin
                if (fin1 == 0) fin1 = c;
                else if (fin2 == 0) fin2 = c;
            end
            if (b_fin && b_fin_cyc == 0) b_fin_cyc = c;
            abort = (c == abort_at);
            if (c == rst_at) begin
                #2 n_rst = 1'b0;
                #1;
                chk("async_rst_a", int'(a_out), 0);
                chk("async_rst_b", int'(b_out), 0);
            end
            if (c == rst_at + 2) n_rst = 1'b1;
        end
        hash_enable = 1'b0;
        skip_first  = 1'b0;
        abort       = 1'b0;
        $display("job sf=%0d hold=%0d: fin=%0d/%0d busy=%0d comp1=%0d lastadd=%0d bfin=%0d",
                 sf, hold, fin1, fin2, busy_cnt, first_comp, last_add, b_fin_cyc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a", int'(a_out), 0);
        chk("reset_b", int'(b_out), 0);
        #2 n_rst = 1'b1;
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);

        run_job(1'b0, 1'b0, 0, 0, 360);
        chk("full_first_comp", first_comp, 49);
        chk("full_last_add", last_add, 339);
        chk("full_finished", fin1, 340);
        chk("full_busy_cycles", busy_cnt, 340);
        chk("full_pass_start", pass1, 0);
        chk("small_finished", b_fin_cyc, 4);

        run_job(1'b1, 1'b0, 0, 0, 250);
        chk("skip_pass_start", pass1, 1);
        chk("skip_finished", fin1, 227);
        chk("skip_busy_cycles", busy_cnt, 227);
        chk("small_skip_pass", b_pass1, 0);
        chk("small_skip_finished", b_fin_cyc, 4);

        run_job(1'b0, 1'b0, 172, 0, 200);
        chk("abort_finished", fin1, 0);
        chk("abort_busy_cycles", busy_cnt, 172);

        run_job(1'b0, 1'b0, 0, 0, 345);
        chk("after_abort_finished", fin1, 340);

        run_job(1'b0, 1'b0, 0, 230, 260);
        chk("rst_finished", fin1, 0);
        chk("rst_busy_cycles", busy_cnt, 230);

        run_job(1'b0, 1'b1, 0, 0, 700);
        chk("held_fin1", fin1, 340);
        chk("held_next_msa", next_msa, 342);
        chk("held_fin2", fin2, 681);
        repeat (400) @(posedge clk);

        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            hash_enable = ($urandom % 4) == 0;
            skip_first  = $urandom % 2;
            abort       = ($urandom % 400) == 0;
            if (($urandom % 1500) == 0) begin
                #3 n_rst = 1'b0;
                #3 n_rst = 1'b1;
            end
        end
        @(negedge clk);
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
